// File: rtl/verify_seq_if.sv
// Byte-stream port bundle for the frame validator: a qualified input byte plus the
// published verdict, its announcement strobe and the recogniser state for observation.
interface verify_seq_if;
    // ascii_char is meaningful only in a cycle with char_valid=1; there is no ready,
    // so every qualified cycle is consumed as one byte.
    // output_strobe is a one-cycle pulse; sequence_valid is stable whenever it is high.
    logic [7:0] ascii_char;
    logic       char_valid;
    logic       sequence_valid;
    logic       output_strobe;
    logic [2:0] state_dbg;

    modport master (
        output ascii_char,
        output char_valid,
        input  sequence_valid,
        input  output_strobe,
        input  state_dbg
    );

    modport slave (
        input  ascii_char,
        input  char_valid,
        output sequence_valid,
        output output_strobe,
        output state_dbg
    );
endinterface

// File: rtl/verify_seq.sv
// NUL-framed recogniser for <digits><op><letters>; the verdict of each closed frame is
// announced by a single strobe aligned to the TX bit-rate tick.
module verify_seq #(
    parameter int UART_TX_baud = 115200,
    parameter int freq         = 50000000
) (
    input  logic         clk,
    input  logic         rst,
    verify_seq_if.slave  bus
);
    localparam int DIV_RAW = freq / UART_TX_baud;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DIG   = 3'd2,
        OP    = 3'd3,
        LET   = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic            pending;
    logic            eval;
    logic            is_nul, is_digit, is_op, is_let;

    assign is_nul   = (bus.ascii_char == 8'h00);
    assign is_digit = (bus.ascii_char >= 8'h30) && (bus.ascii_char <= 8'h39);
    assign is_op    = (bus.ascii_char == 8'h2B) || (bus.ascii_char == 8'h2D) ||
                      (bus.ascii_char == 8'h2A) || (bus.ascii_char == 8'h2F);
    assign is_let   = (bus.ascii_char >= 8'h41) && (bus.ascii_char <= 8'h5A);

    // A NUL closes a frame only once at least one byte has been framed.
    assign eval = bus.char_valid && is_nul &&
                  ((state == DIG) || (state == OP) || (state == LET) || (state == ERR));

    assign tick          = (tick_cnt == CW'(DIV - 1));
    assign bus.state_dbg = state;

    always_comb begin
        state_nxt = state;
        if (bus.char_valid) begin
            case (state)
                IDLE:    if (is_nul) state_nxt = START;
                START:   if (is_nul)        state_nxt = START;
                         else if (is_digit) state_nxt = DIG;
                         else               state_nxt = ERR;
                DIG:     if (is_nul)        state_nxt = START;
                         else if (is_digit) state_nxt = DIG;
                         else if (is_op)    state_nxt = OP;
                         else               state_nxt = ERR;
                OP:      if (is_nul)        state_nxt = START;
                         else if (is_let)   state_nxt = LET;
                         else               state_nxt = ERR;
                LET:     if (is_nul)        state_nxt = START;
                         else if (is_let)   state_nxt = LET;
                         else               state_nxt = ERR;
                ERR:     if (is_nul)        state_nxt = START;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // A fresh evaluation outranks a coinciding tick so only the newest verdict is announced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.sequence_valid <= 1'b0;
            bus.output_strobe  <= 1'b0;
            pending            <= 1'b0;
        end else begin
            bus.output_strobe <= tick && pending && !eval;
            if (eval) begin
                bus.sequence_valid <= (state == LET);
                pending            <= 1'b1;
            end else if (tick && pending) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_verify_seq.sv
// Directed frames for the validator with an expected-verdict queue drained by a
// strobe monitor that also bounds the announcement latency.
module tb_verify_seq;
    localparam int DIV = 10;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   fails;
    logic prev_strobe;

    logic [0:0] exp_q[$];
    int         eval_q[$];

    verify_seq_if bus ();

    verify_seq #(
        .UART_TX_baud(20),
        .freq        (200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        bus.ascii_char = b;
        bus.char_valid = 1'b1;
        repeat (hold) @(negedge clk);
        bus.char_valid = 1'b0;
        bus.ascii_char = 8'h00;
        repeat (DIV - 1 - hold) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1);
    endtask

    task automatic close_frame(input logic exp_v);
        @(negedge clk);
        exp_q.push_back(exp_v);
        eval_q.push_back(cyc + 1);
        bus.ascii_char = 8'h00;
        bus.char_valid = 1'b1;
        @(negedge clk);
        bus.char_valid = 1'b0;
        repeat (DIV - 2) @(negedge clk);
    endtask

    task automatic send_frame(input string s, input logic exp_v);
        send_byte(8'h00, 1);
        send_str(s);
        close_frame(exp_v);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 * DIV && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: strobe timeout, %0d verdicts still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
            eval_q.delete();
        end
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            if (bus.output_strobe) begin
                if (prev_strobe) begin
                    checks++;
                    fails++;
                    $display("FAIL strobe_width: strobe high two cycles at cyc %0d, required one", cyc);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_strobe: strobe at cyc %0d, required no strobe", cyc);
                end else begin
                    logic [0:0] exp_v;
                    int         ev;
                    int         lat;
                    exp_v = exp_q.pop_front();
                    ev    = eval_q.pop_front();
                    lat   = cyc - ev;
                    checks++;
                    if (bus.sequence_valid !== exp_v[0]) begin
                        fails++;
                        $display("FAIL verdict: sequence_valid=%0b, required %0b", bus.sequence_valid, exp_v[0]);
                    end
                    checks++;
                    if (lat < 1 || lat > DIV) begin
                        fails++;
                        $display("FAIL strobe_latency: %0d clocks, required 1..%0d", lat, DIV);
                    end
                end
            end
            prev_strobe <= bus.output_strobe;
        end else begin
            prev_strobe <= 1'b0;
        end
    end

    initial begin
        cyc            = 0;
        checks         = 0;
        fails          = 0;
        rst            = 1'b0;
        bus.ascii_char = 8'h00;
        bus.char_valid = 1'b0;

        // 1: reset then idle
        repeat (100) @(negedge clk);
        check_val("reset_seq_valid", {2'b0, bus.sequence_valid}, 3'd0);
        check_val("reset_strobe", {2'b0, bus.output_strobe}, 3'd0);
        check_val("reset_state", bus.state_dbg, 3'd0);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check_val("idle_seq_valid", {2'b0, bus.sequence_valid}, 3'd0);
        check_val("idle_state", bus.state_dbg, 3'd0);

        // 2..5: directed frames
        send_frame("123+X", 1'b1);
        drain("frame_123+X");
        check_val("hold_123+X", {2'b0, bus.sequence_valid}, 3'd1);
        send_frame("456*ABC", 1'b1);
        drain("frame_456*ABC");
        send_frame("1A+XX", 1'b0);
        drain("frame_1A+XX");
        check_val("hold_1A+XX", {2'b0, bus.sequence_valid}, 3'd0);
        check_val("state_after_close", bus.state_dbg, 3'd1);
        send_frame("456*", 1'b0);
        drain("frame_456*");
        send_frame("456*ABC", 1'b1);
        drain("frame_456*ABC_again");

        // 6: empty frame keeps the verdict
        send_byte(8'h00, 1);
        send_byte(8'h00, 1);
        repeat (2 * DIV) @(negedge clk);
        check_val("empty_frame_hold", {2'b0, bus.sequence_valid}, 3'd1);
        check_val("empty_frame_state", bus.state_dbg, 3'd1);

        // 6: reset mid-frame clears verdict and state
        send_str("12");
        check_val("midframe_state", bus.state_dbg, 3'd2);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midreset_seq_valid", {2'b0, bus.sequence_valid}, 3'd0);
        check_val("midreset_state", bus.state_dbg, 3'd0);
        rst = 1'b1;
        repeat (2 * DIV) @(negedge clk);

        // 6: bytes before the first NUL are ignored
        send_str("9+Q");
        check_val("unframed_state", bus.state_dbg, 3'd0);
        check_val("unframed_seq_valid", {2'b0, bus.sequence_valid}, 3'd0);
        send_frame("9+Q", 1'b1);
        drain("frame_after_reset");

        // held char_valid counts one byte per cycle: "555/QQ"
        send_byte(8'h00, 1);
        send_byte(8'h35, 3);
        send_byte(8'h2F, 1);
        send_byte(8'h51, 2);
        close_frame(1'b1);
        drain("frame_held_valid");
        // "55//Q" via a held operator must be rejected
        send_byte(8'h00, 1);
        send_byte(8'h35, 2);
        send_byte(8'h2F, 2);
        send_byte(8'h51, 1);
        close_frame(1'b0);
        drain("frame_held_op");
        check_val("final_seq_valid", {2'b0, bus.sequence_valid}, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
